// File: rtl/div_pkg.sv
// Shared types and constants for the sequential 32-bit integer divider.
package div_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITER  = XLEN;
  localparam int unsigned CNT_W = $clog2(ITER);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } div_state_e;

endpackage

// File: rtl/div_if.sv
// Request/response bundle between a divider client and div_seq.
interface div_if;

  logic                       go;
  logic                       sign;
  logic [div_pkg::XLEN-1:0]   dividend;
  logic [div_pkg::XLEN-1:0]   divisor;
  logic                       busy;
  logic                       done;
  logic [div_pkg::XLEN-1:0]   quotient;
  logic [div_pkg::XLEN-1:0]   remainder;

  modport master (
    output go, sign, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  go, sign, dividend, divisor,
    output busy, done, quotient, remainder
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step on a 33-bit partial remainder.
module div_step
  import div_pkg::*;
(
  input  logic [XLEN:0]   rem_in,
  input  logic            dividend_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic            q_bit
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  assign shifted = {rem_in[XLEN-1:0], dividend_msb};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};

  // A set top bit means the true shifted value exceeds any 32-bit divisor.
  assign q_bit   = rem_in[XLEN] | ~diff[XLEN+1];
  assign rem_out = q_bit ? diff[XLEN:0] : shifted;

endmodule

// File: rtl/div_seq.sv
// Sequential signed/unsigned 32-bit divider: 32 restoring steps plus a sign fix-up,
// with an optional single-cycle path for divide-by-zero and signed overflow.
module div_seq
  import div_pkg::*;
#(
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  div_if.slave bus
);

  div_state_e state, state_next;
  logic [CNT_W-1:0] cnt;
  logic load, fast, step, fix;

  logic signed [XLEN-1:0] dividend_s, divisor_s;
  logic [XLEN-1:0] dividend_abs, divisor_abs;
  logic div_zero, overflow, special;

  logic [XLEN-1:0] q_reg, dvsr_reg;
  logic [XLEN:0]   rem_reg, rem_step;
  logic            q_bit, neg_q, neg_r;
  logic [XLEN-1:0] quotient_r, remainder_r;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  assign dividend_s   = bus.dividend;
  assign divisor_s    = bus.divisor;
  assign dividend_abs = (bus.sign && dividend_s < 0) ? negate(bus.dividend) : bus.dividend;
  assign divisor_abs  = (bus.sign && divisor_s < 0)  ? negate(bus.divisor)  : bus.divisor;
  assign div_zero     = (bus.divisor == '0);
  assign overflow     = bus.sign && (bus.dividend == INT_MIN) && (bus.divisor == '1);
  assign special      = div_zero || overflow;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    fast       = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.go) begin
          load = 1'b1;
          if (FAST_SPECIAL && special) begin
            fast       = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = S_CALC;
          end
        end
      end
      S_CALC: begin
        step = 1'b1;
        if (cnt == LAST_ITER) state_next = S_FIX;
      end
      S_FIX: begin
        fix        = 1'b1;
        state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  div_step u_step (
    .rem_in       (rem_reg),
    .dividend_msb (q_reg[XLEN-1]),
    .divisor      (dvsr_reg),
    .rem_out      (rem_step),
    .q_bit        (q_bit)
  );

  // Operand capture and iteration: the dividend shifts out of q_reg as quotient bits shift in.
  always_ff @(posedge clk) begin
    if (load) begin
      rem_reg  <= '0;
      q_reg    <= dividend_abs;
      dvsr_reg <= divisor_abs;
      // Divide-by-zero keeps the all-ones quotient regardless of operand signs.
      neg_q    <= bus.sign && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]) && !div_zero;
      neg_r    <= bus.sign && bus.dividend[XLEN-1];
    end else if (step) begin
      rem_reg  <= rem_step;
      q_reg    <= {q_reg[XLEN-2:0], q_bit};
    end
  end

  // Result stage: outputs change only when entering DONE and otherwise hold.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else begin
      if (load)      cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;

      if (fast) begin
        quotient_r  <= div_zero ? '1 : INT_MIN;
        remainder_r <= div_zero ? bus.dividend : '0;
      end else if (fix) begin
        quotient_r  <= neg_q ? negate(q_reg) : q_reg;
        remainder_r <= neg_r ? negate(rem_reg[XLEN-1:0]) : rem_reg[XLEN-1:0];
      end
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench: one fast-special and one iterative-only divider driven in lockstep.
module tb_div_seq;

  logic        clk;
  logic        reset_n;
  logic        go;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;

  int n_tests = 0;
  int n_fail  = 0;

  div_if if_f ();
  div_if if_s ();

  assign if_f.go       = go;
  assign if_f.sign     = sign;
  assign if_f.dividend = dividend;
  assign if_f.divisor  = divisor;
  assign if_s.go       = go;
  assign if_s.sign     = sign;
  assign if_s.dividend = dividend;
  assign if_s.divisor  = divisor;

  div_seq #(.FAST_SPECIAL(1'b1)) dut_f (.clk(clk), .reset_n(reset_n), .bus(if_f.slave));
  div_seq #(.FAST_SPECIAL(1'b0)) dut_s (.clk(clk), .reset_n(reset_n), .bus(if_s.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".busy_f"}, 32'(if_f.busy), 32'd0);
    chk({tag, ".done_f"}, 32'(if_f.done), 32'd0);
    chk({tag, ".q_f"},    if_f.quotient,  32'd0);
    chk({tag, ".r_f"},    if_f.remainder, 32'd0);
    chk({tag, ".busy_s"}, 32'(if_s.busy), 32'd0);
    chk({tag, ".done_s"}, 32'(if_s.done), 32'd0);
    chk({tag, ".q_s"},    if_s.quotient,  32'd0);
    chk({tag, ".r_s"},    if_s.remainder, 32'd0);
  endtask

  // Latency counts clock edges starting with the accepting edge as 1.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq,
                        input logic [31:0] er, input int elat_f);
    int cyc, lat_f, lat_s;
    logic [31:0] qf, rf, qs, rs;
    lat_f = 0; lat_s = 0;
    qf = '0; rf = '0; qs = '0; rs = '0;
    @(negedge clk);
    go = 1'b1; sign = sgn; dividend = a; divisor = b;
    @(posedge clk); #1;
    cyc = 1;
    go = 1'b0; dividend = ~a; divisor = b + 32'd1;
    while ((lat_f == 0 || lat_s == 0) && cyc < 100) begin
      if (lat_f == 0 && if_f.done) begin lat_f = cyc; qf = if_f.quotient; rf = if_f.remainder; end
      if (lat_s == 0 && if_s.done) begin lat_s = cyc; qs = if_s.quotient; rs = if_s.remainder; end
      if (lat_f == 0 || lat_s == 0) begin @(posedge clk); #1; cyc++; end
    end
    chk({tag, ".q_f"},   qf, eq);
    chk({tag, ".r_f"},   rf, er);
    chk({tag, ".lat_f"}, 32'(lat_f), 32'(elat_f));
    chk({tag, ".q_s"},   qs, eq);
    chk({tag, ".r_s"},   rs, er);
    chk({tag, ".lat_s"}, 32'(lat_s), 32'd34);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 32'(if_s.done), 32'd0);
    chk({tag, ".busy_end"},   32'(if_s.busy), 32'd0);
    chk({tag, ".hold_q_f"},   if_f.quotient, eq);
    chk({tag, ".hold_r_s"},   if_s.remainder, er);
  endtask

  task automatic back_to_back();
    int n_done;
    n_done = 0;
    @(negedge clk);
    go = 1'b1; sign = 1'b0; dividend = 32'd20; divisor = 32'd3;
    @(posedge clk); #1;
    dividend = 32'd50; divisor = 32'd5;
    for (int cyc = 1; cyc <= 75; cyc++) begin
      n_done += int'(if_f.done) + int'(if_s.done);
      if (cyc == 34) begin
        chk("b2b.op1.done_s", 32'(if_s.done), 32'd1);
        chk("b2b.op1.q_s", if_s.quotient, 32'd6);
        chk("b2b.op1.r_s", if_s.remainder, 32'd2);
        chk("b2b.op1.q_f", if_f.quotient, 32'd6);
      end
      if (cyc == 35) chk("b2b.idle_gap", 32'(if_s.busy), 32'd0);
      if (cyc == 36) begin
        chk("b2b.op2.busy", 32'(if_s.busy), 32'd1);
        go = 1'b0;
      end
      if (cyc == 50) go = 1'b1;
      if (cyc == 51) begin go = 1'b0; dividend = 32'd1; divisor = 32'd1; end
      if (cyc == 69) begin
        chk("b2b.op2.done_f", 32'(if_f.done), 32'd1);
        chk("b2b.op2.q_s", if_s.quotient, 32'd10);
        chk("b2b.op2.r_s", if_s.remainder, 32'd0);
        chk("b2b.op2.q_f", if_f.quotient, 32'd10);
      end
      @(posedge clk); #1;
    end
    chk("b2b.done_count", 32'(n_done), 32'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; reset_n = 1'b0; go = 1'b1; sign = 1'b0;
    dividend = 32'd9; divisor = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    @(negedge clk);
    reset_n = 1'b1; go = 1'b0;
    @(posedge clk); #1;
    chk("post_reset.busy", 32'(if_s.busy), 32'd0);

    run_op("u100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          34);
    run_op("s-7_2",     1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFD,  32'hFFFF_FFFF,  34);
    run_op("s7_-2",     1'b1, 32'h0000_0007,  32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'h0000_0001,  34);
    run_op("u5_0",      1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1);
    run_op("s5_0",      1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1);
    run_op("s-5_0",     1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1);
    run_op("s_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1);
    run_op("u_ovf_ops", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  34);
    run_op("u_big",     1'b0, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0FFF_FFFF,  32'h0000_000F,  34);

    back_to_back();

    @(negedge clk);
    go = 1'b1; sign = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_idle_zero("mid_reset");

    run_op("after_rst", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
